writeback_stage: RTL and testbench

- Final pipeline stage of the core, directly upstream of the register file.
- Accepts retiring ops (ALU result or load request), waits for the DMEM load response, aligns and extends load data.
- Drives the register-file write port: destination select, write data and write enable.
- Exposes the in-flight destination for hazard and forwarding logic.

---
 rtl/writeback_stage_pkg.sv | 16 +
 rtl/writeback_stage_load_align.sv | 40 ++++
 rtl/writeback_stage.sv | 118 +++++++++++
 tb/tb_writeback_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: load funct3 codes and FSM states.
package writeback_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Lane select and sign/zero extension of a word-aligned DMEM read, plus the
// misalignment / illegal-funct3 check for the requested load type.
module load_align
  import writeback_stage_pkg::*;
#(
  parameter int bits = 32
) (
  input  logic [bits-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [bits-1:0] data,
  output logic            misalign
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = word[{addr[1], 4'b0000} +: 16];
    data      = word;
    misalign  = 1'b0;
    case (funct3)
      F3_LB:  data = bits'(byte_lane);
      F3_LBU: data = bits'($unsigned(byte_lane));
      F3_LH: begin
        data     = bits'(half_lane);
        misalign = addr[0];
      end
      F3_LHU: begin
        data     = bits'($unsigned(half_lane));
        misalign = addr[0];
      end
      F3_LW:  misalign = (addr != 2'b00);
      // 011, 110, 111 are not loads this stage can retire
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final core stage: retires ALU results and load responses into the register
// file write port, tracking the in-flight destination for hazard logic.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int bits            = 32,
  parameter int no_of_registers = 32,
  parameter int mem_timeout     = 15,
  localparam int rd_w           = $clog2(no_of_registers)
) (
  input  logic            clk,
  input  logic            async_reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [rd_w-1:0] issue_rd,
  input  logic            issue_is_load,
  input  logic [2:0]      issue_funct3,
  input  logic [bits-1:0] issue_result,
  input  logic            mem_rvalid,
  input  logic [bits-1:0] mem_rdata,
  output logic [rd_w-1:0] write_en,
  output logic [bits-1:0] write_data,
  output logic            reg_en,
  output logic [rd_w-1:0] busy_rd,
  output logic            load_err
);

  localparam logic [7:0] CNT_LAST = 8'(mem_timeout - 1);

  wb_state_t       state;
  logic [rd_w-1:0] rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_q;
  logic [7:0]      cnt;

  logic            accept;
  logic            waiting;
  logic [1:0]      align_addr;
  logic [2:0]      align_funct3;
  logic [bits-1:0] align_data;
  logic            align_misalign;

  assign waiting     = (state == ST_WAIT_MEM);
  assign issue_ready = !waiting;
  assign accept      = issue_valid && issue_ready;
  assign busy_rd     = (state == ST_IDLE) ? '0 : rd_q;

  // One aligner serves both the issue-time misalign check and the response path
  assign align_addr   = waiting ? addr_q   : issue_result[1:0];
  assign align_funct3 = waiting ? funct3_q : issue_funct3;

  load_align #(.bits(bits)) u_load_align (
    .word     (mem_rdata),
    .addr     (align_addr),
    .funct3   (align_funct3),
    .data     (align_data),
    .misalign (align_misalign)
  );

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state      <= ST_IDLE;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      write_en   <= '0;
      write_data <= '0;
      reg_en     <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      reg_en   <= 1'b0;
      load_err <= 1'b0;
      case (state)
        ST_WAIT_MEM: begin
          // A response on the expiring cycle still wins over the timeout
          if (mem_rvalid) begin
            state <= ST_WRITE;
            if (rd_q != '0) begin
              reg_en     <= 1'b1;
              write_en   <= rd_q;
              write_data <= align_data;
            end
          end else if (cnt == CNT_LAST) begin
            state    <= ST_IDLE;
            load_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (accept) begin
            rd_q <= issue_rd;
            if (!issue_is_load) begin
              state <= ST_WRITE;
              if (issue_rd != '0) begin
                reg_en     <= 1'b1;
                write_en   <= issue_rd;
                write_data <= issue_result;
              end
            end else if (align_misalign) begin
              state    <= ST_IDLE;
              load_err <= 1'b1;
            end else begin
              state    <= ST_WAIT_MEM;
              funct3_q <= issue_funct3;
              addr_q   <= issue_result[1:0];
              cnt      <= '0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_is_load;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  write_en;
  logic [31:0] write_data;
  logic        reg_en;
  logic [4:0]  busy_rd;
  logic        load_err;

  int vectors     = 0;
  int miscompares = 0;

  writeback_stage #(.bits(32), .no_of_registers(32), .mem_timeout(15)) dut (
    .clk           (clk),
    .async_reset   (async_reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rd      (issue_rd),
    .issue_is_load (issue_is_load),
    .issue_funct3  (issue_funct3),
    .issue_result  (issue_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .write_en      (write_en),
    .write_data    (write_data),
    .reg_en        (reg_en),
    .busy_rd       (busy_rd),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res);
    issue_valid   = 1'b1;
    issue_is_load = 1'b0;
    issue_funct3  = 3'b000;
    issue_rd      = rd;
    issue_result  = res;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
    issue_valid   = 1'b1;
    issue_is_load = 1'b1;
    issue_funct3  = f3;
    issue_rd      = rd;
    issue_result  = addr;
  endtask

  task automatic idle_inputs;
    issue_valid   = 1'b0;
    issue_is_load = 1'b0;
    mem_rvalid    = 1'b0;
  endtask

  // Load accepted, 'gap' cycles with no response, then response with rdata
  task automatic load_op(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata, input int gap,
                         input logic [31:0] exp);
    issue_load(rd, f3, addr);
    tick;
    idle_inputs();
    for (int i = 0; i < gap; i++) begin
      check_vec({tag, "_wait_rdy"}, 32'(issue_ready), 32'd0);
      check_vec({tag, "_wait_busy"}, 32'(busy_rd), 32'(rd));
      check_vec({tag, "_wait_err"}, 32'(load_err), 32'd0);
      tick;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick;
    mem_rvalid = 1'b0;
    check_vec({tag, "_reg_en"}, 32'(reg_en), 32'd1);
    check_vec({tag, "_wr_sel"}, 32'(write_en), 32'(rd));
    check_vec({tag, "_wr_data"}, write_data, exp);
    check_vec({tag, "_err"}, 32'(load_err), 32'd0);
    tick;
    check_vec({tag, "_reg_en_off"}, 32'(reg_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    async_reset  = 1'b0;
    issue_rd     = '0;
    issue_funct3 = '0;
    issue_result = '0;
    mem_rdata    = '0;
    idle_inputs();
    tick;
    tick;
    check_vec("rst_reg_en", 32'(reg_en), 32'd0);
    check_vec("rst_wr_sel", 32'(write_en), 32'd0);
    check_vec("rst_wr_data", write_data, 32'd0);
    check_vec("rst_busy", 32'(busy_rd), 32'd0);
    check_vec("rst_err", 32'(load_err), 32'd0);
    check_vec("rst_ready", 32'(issue_ready), 32'd1);
    async_reset = 1'b1;
    tick;

    // Reset while a load waits for memory
    issue_load(5'd5, F3_LW, 32'h100);
    tick;
    idle_inputs();
    check_vec("midld_ready", 32'(issue_ready), 32'd0);
    check_vec("midld_busy", 32'(busy_rd), 32'd5);
    async_reset = 1'b0;
    #2;
    check_vec("midld_rst_ready", 32'(issue_ready), 32'd1);
    check_vec("midld_rst_busy", 32'(busy_rd), 32'd0);
    tick;
    async_reset = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'hAAAA_5555;
    tick;
    mem_rvalid = 1'b0;
    check_vec("midld_stale_reg_en", 32'(reg_en), 32'd0);
    check_vec("midld_stale_data", write_data, 32'd0);
    check_vec("midld_stale_sel", 32'(write_en), 32'd0);
    tick;
    check_vec("midld_stale_reg_en2", 32'(reg_en), 32'd0);

    // Back-to-back ALU ops, middle one to x0
    issue_alu(5'd3, 32'hDEAD_BEEF);
    tick;
    check_vec("alu0_reg_en", 32'(reg_en), 32'd1);
    check_vec("alu0_sel", 32'(write_en), 32'd3);
    check_vec("alu0_data", write_data, 32'hDEAD_BEEF);
    check_vec("alu0_ready", 32'(issue_ready), 32'd1);
    issue_alu(5'd0, 32'h1);
    tick;
    check_vec("alu1_reg_en", 32'(reg_en), 32'd0);
    check_vec("alu1_hold_data", write_data, 32'hDEAD_BEEF);
    check_vec("alu1_hold_sel", 32'(write_en), 32'd3);
    check_vec("alu1_ready", 32'(issue_ready), 32'd1);
    issue_alu(5'd7, 32'h5);
    tick;
    idle_inputs();
    check_vec("alu2_reg_en", 32'(reg_en), 32'd1);
    check_vec("alu2_sel", 32'(write_en), 32'd7);
    check_vec("alu2_data", write_data, 32'h5);
    check_vec("alu2_busy", 32'(busy_rd), 32'd7);
    tick;
    check_vec("alu_done_reg_en", 32'(reg_en), 32'd0);
    check_vec("alu_done_busy", 32'(busy_rd), 32'd0);
    check_vec("alu_done_data", write_data, 32'h5);

    // Lane select and extension
    load_op("lb",  5'd1, F3_LB,  32'h103, 32'h80FF_1234, 0, 32'hFFFF_FF80);
    load_op("lbu", 5'd2, F3_LBU, 32'h103, 32'h80FF_1234, 0, 32'h0000_0080);
    load_op("lh",  5'd3, F3_LH,  32'h102, 32'h80FF_1234, 0, 32'hFFFF_80FF);
    load_op("lhu", 5'd4, F3_LHU, 32'h102, 32'h80FF_1234, 0, 32'h0000_80FF);
    load_op("lb1", 5'd11, F3_LB, 32'h101, 32'h80FF_1234, 1, 32'h0000_0012);

    // Response four cycles after accept
    load_op("lw_lat", 5'd9, F3_LW, 32'h100, 32'h1234_5678, 3, 32'h1234_5678);

    // Misaligned word load
    issue_load(5'd6, F3_LW, 32'h102);
    tick;
    idle_inputs();
    check_vec("mis_err", 32'(load_err), 32'd1);
    check_vec("mis_reg_en", 32'(reg_en), 32'd0);
    check_vec("mis_ready", 32'(issue_ready), 32'd1);
    check_vec("mis_busy", 32'(busy_rd), 32'd0);
    tick;
    check_vec("mis_err_pulse", 32'(load_err), 32'd0);
    check_vec("mis_reg_en2", 32'(reg_en), 32'd0);

    // Illegal funct3 counts as misaligned
    issue_load(5'd6, 3'b011, 32'h100);
    tick;
    idle_inputs();
    check_vec("bad_f3_err", 32'(load_err), 32'd1);
    tick;

    // Timeout: 15 WAIT_MEM cycles without a response
    issue_load(5'd8, F3_LW, 32'h200);
    tick;
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      check_vec("to_wait_err", 32'(load_err), 32'd0);
      check_vec("to_wait_ready", 32'(issue_ready), 32'd0);
      tick;
    end
    check_vec("to_last_err", 32'(load_err), 32'd0);
    tick;
    check_vec("to_err", 32'(load_err), 32'd1);
    check_vec("to_reg_en", 32'(reg_en), 32'd0);
    check_vec("to_ready", 32'(issue_ready), 32'd1);
    check_vec("to_busy", 32'(busy_rd), 32'd0);
    tick;
    check_vec("to_err_pulse", 32'(load_err), 32'd0);

    // Response on the expiring cycle is still written
    load_op("to_edge", 5'd10, F3_LW, 32'h204, 32'hCAFE_F00D, 14, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
